// File: rtl/target_compositor.sv
// Target/leaf/background pixel compositor with delayed VGA timing.
// Timing signals run through a SYNC_DELAY-stage delay line plus an output
// register; pixel inputs (which already lag timing by SYNC_DELAY) are muxed
// and registered once, so both leave aligned.
// Optional feature: define COMPOSITOR_FLASH_EN to enable the hit-triggered
// target flash (colour inversion for FLASH_FRAMES frames). Without it the
// FSM is absent, hit is ignored and flashing is tied low.
module target_compositor #(
  parameter int unsigned SYNC_DELAY   = 3,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [23:0] target_pixel,
  input  logic [23:0] leaf_pixel,
  input  logic [23:0] bg_pixel,
  input  logic        hit,
  output logic [23:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank,
  output logic        flashing
);

  // Delay-line stages; index SYNC_DELAY-1 is the oldest sample.
  logic [SYNC_DELAY-1:0] hs_dly;
  logic [SYNC_DELAY-1:0] vs_dly;
  logic [SYNC_DELAY-1:0] bl_dly;

  logic        dly_blank;
  logic        invert_target;
  logic [23:0] rgb_d;

  assign dly_blank = bl_dly[SYNC_DELAY-1];

  // Timing delay line; reset loads the inactive levels so no false vsync edge appears.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_dly <= '1;
      vs_dly <= '1;
      bl_dly <= '1;
    end else begin
      hs_dly[0] <= hsync;
      vs_dly[0] <= vsync;
      bl_dly[0] <= blank;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_dly[i] <= hs_dly[i-1];
        vs_dly[i] <= vs_dly[i-1];
        bl_dly[i] <= bl_dly[i-1];
      end
    end
  end

  // Layer priority mux: target over leaf over background, black while blanked.
  always_comb begin
    rgb_d = bg_pixel;
    if (leaf_pixel != 24'h000000) begin
      rgb_d = leaf_pixel;
    end
    if (target_pixel != 24'h000000) begin
      rgb_d = invert_target ? ~target_pixel : target_pixel;
    end
    if (dly_blank) begin
      rgb_d = 24'h000000;
    end
  end

  // Output register stage for timing and composited colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_rgb   <= 24'h000000;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      vga_blank <= 1'b1;
    end else begin
      vga_rgb   <= rgb_d;
      vga_hsync <= hs_dly[SYNC_DELAY-1];
      vga_vsync <= vs_dly[SYNC_DELAY-1];
      vga_blank <= dly_blank;
    end
  end

`ifdef COMPOSITOR_FLASH_EN

  typedef enum logic [0:0] {StIdle, StFlash} state_e;

  localparam int unsigned CntW = $clog2(FLASH_FRAMES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(FLASH_FRAMES);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            frame_tick;
  logic            unused_timing;

  // vga_vsync holds the previous value of the last delay stage, so this is
  // a falling-edge compare against a register.
  assign frame_tick    = vga_vsync & ~vs_dly[SYNC_DELAY-1];
  assign invert_target = (state_q == StFlash);
  assign unused_timing = ^{hcount, vcount};

  // Flash FSM next state: hit loads/reloads the frame count, ticks count down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (hit) begin
          cnt_d   = CntLoad;
          state_d = StFlash;
        end
      end
      StFlash: begin
        if (hit) begin
          cnt_d = CntLoad;
        end else if (frame_tick) begin
          if (cnt_q == CntW'(1)) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Flash FSM state, counter and registered flashing flag (tracks state exactly).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      flashing <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flashing <= (state_d == StFlash);
    end
  end

`else

  logic unused_inputs;

  assign invert_target = 1'b0;
  assign flashing      = 1'b0;
  assign unused_inputs = ^{hcount, vcount, hit};

`endif

endmodule
